// File: rtl/duck_hunt_pkg.sv
// duck_hunt_pkg
//   Shared types and default parameter values for the light-gun hit detector.
//   gun_state_t : shot sequencing states of zapper_hit_detector.
//   DEF_*       : default values for the detector parameters.
package duck_hunt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      BLACK_WIN,
      WHITE_WIN,
      REPORT,
      WAIT_RELEASE
   } gun_state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
   localparam int unsigned DEF_SETTLE_CYCLES   = 1600;
   localparam int unsigned DEF_LIGHT_MIN       = 64;
   localparam int unsigned DEF_DARK_MAX        = 16;
   localparam int unsigned DEF_CNT_W           = 20;

endpackage

// File: rtl/zapper_hit_detector_trigger_debouncer.sv
// trigger_debouncer
//   Two-flop synchronizer plus stability counter for the gun trigger switch.
//   Ports:
//     clk_i    in   clock
//     reset_i  in   synchronous active-high reset
//     raw_i    in   asynchronous, bouncy trigger switch
//     level_o  out  debounced level (registered)
//     rise_o   out  high in the cycle whose clock edge raises level_o
//     fall_o   out  high in the cycle whose clock edge lowers level_o
module trigger_debouncer
   import duck_hunt_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any sample that agrees with the current level restarts the count; the
   // DEBOUNCE_CYCLES-th consecutive disagreeing sample flips the level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = level_d & ~level_q;
   assign fall_o  = ~level_d & level_q;

endmodule

// File: rtl/zapper_hit_detector.sv
// zapper_hit_detector
//   Gun-side timing for the black-frame / white-frame flash test. Debounces
//   the trigger, then counts photodiode light samples in one black and one
//   white frame window and reports one hit or miss per shot.
//   Ports:
//     clk          in   pixel clock (shared with VGA timing / pattern logic)
//     reset        in   synchronous active-high reset
//     frame_start  in   1-clk pulse at the start of each frame
//     trigger_raw  in   asynchronous, bouncy trigger switch
//     light_raw    in   asynchronous photodiode comparator, 1 = light
//     trigger      out  debounced trigger level, feeds the pattern generator
//     busy         out  high while ARMED or inside a flash window
//     hit          out  1-clk pulse when the shot scores
//     miss         out  1-clk pulse when the shot fails
module zapper_hit_detector
   import duck_hunt_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
   parameter int unsigned LIGHT_MIN       = DEF_LIGHT_MIN,
   parameter int unsigned DARK_MAX        = DEF_DARK_MAX,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_start,
   input  logic trigger_raw,
   input  logic light_raw,
   output logic trigger,
   output logic busy,
   output logic hit,
   output logic miss
);

   localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] LIGHT_LIM  = CNT_W'(LIGHT_MIN);
   localparam logic [CNT_W-1:0] DARK_LIM   = CNT_W'(DARK_MAX);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic trig_level, trig_rise, trig_fall;

   trigger_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debouncer (
      .clk_i   (clk),
      .reset_i (reset),
      .raw_i   (trigger_raw),
      .level_o (trig_level),
      .rise_o  (trig_rise),
      .fall_o  (trig_fall)
   );

   logic             light_s1_q, light_s2_q;
   gun_state_t       state_q, state_d;
   logic [CNT_W-1:0] settle_q, settle_d;
   logic [CNT_W-1:0] dark_q, dark_d;
   logic [CNT_W-1:0] lit_q, lit_d;
   logic             sample_ok;
   logic             pass;

   // The frame_start edge closing a window still contributes its sample, so a
   // window of N clocks yields N - SETTLE_CYCLES counted samples.
   assign sample_ok = (settle_q == SETTLE_LIM);
   assign pass      = (lit_q >= LIGHT_LIM) && (dark_q <= DARK_LIM);

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      dark_d   = dark_q;
      lit_d    = lit_q;

      if (frame_start) begin
         settle_d = '0;
      end else if (!sample_ok) begin
         settle_d = settle_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (trig_rise) state_d = ARMED;
         end
         ARMED: begin
            if (frame_start) begin
               if (trig_level) begin
                  state_d = BLACK_WIN;
                  dark_d  = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (!trig_level) begin
               state_d = IDLE;
            end
         end
         BLACK_WIN: begin
            if (sample_ok && light_s2_q) dark_d = sat_inc(dark_q);
            if (frame_start) begin
               state_d = WHITE_WIN;
               lit_d   = '0;
            end
         end
         WHITE_WIN: begin
            if (sample_ok && light_s2_q) lit_d = sat_inc(lit_q);
            if (frame_start) state_d = REPORT;
         end
         REPORT: begin
            state_d = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (!trig_level) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         light_s1_q <= 1'b0;
         light_s2_q <= 1'b0;
         state_q    <= IDLE;
         settle_q   <= '0;
         dark_q     <= '0;
         lit_q      <= '0;
      end else begin
         light_s1_q <= light_raw;
         light_s2_q <= light_s1_q;
         state_q    <= state_d;
         settle_q   <= settle_d;
         dark_q     <= dark_d;
         lit_q      <= lit_d;
      end
   end

   assign trigger = trig_level;
   assign busy    = (state_q == ARMED) || (state_q == BLACK_WIN) || (state_q == WHITE_WIN);
   assign hit     = (state_q == REPORT) && pass;
   assign miss    = (state_q == REPORT) && !pass;

endmodule

// File: tb/tb_zapper_hit_detector.sv
// tb_zapper_hit_detector
//   Directed bench for zapper_hit_detector with small parameters
//   (DEBOUNCE=4, SETTLE=2, LIGHT_MIN=4, DARK_MAX=1) and 40-clk frames.
module tb_zapper_hit_detector;
   import duck_hunt_pkg::*;

   logic clk = 1'b0;
   logic reset, frame_start, trigger_raw, light_raw;
   logic trigger, busy, hit, miss;

   int n_assert = 0;
   int n_fail   = 0;
   int hits     = 0;
   int misses   = 0;
   int both     = 0;
   int p0;
   logic f_hit0, f_miss0, f_busy0, f_busy_mid;
   int   f_pulses;
   logic quiet;

   zapper_hit_detector #(
      .DEBOUNCE_CYCLES (4),
      .SETTLE_CYCLES   (2),
      .LIGHT_MIN       (4),
      .DARK_MAX        (1),
      .CNT_W           (20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .trigger_raw (trigger_raw),
      .light_raw   (light_raw),
      .trigger     (trigger),
      .busy        (busy),
      .hit         (hit),
      .miss        (miss)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (hit)          hits++;
      if (miss)         misses++;
      if (hit && miss)  both++;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One 40-clk frame: frame_start on the first clock; light is 'base' with an
   // optional n-clock pulse of light starting 10 clocks into the frame.
   task automatic frame(input logic base, input int n);
      int start;
      start = hits + misses;
      for (int i = 0; i < 40; i++) begin
         light_raw   = base | ((i >= 10) && (i < 10 + n));
         frame_start = (i == 0);
         tick();
         if (i == 0) begin
            f_hit0  = hit;
            f_miss0 = miss;
            f_busy0 = busy;
         end
         if (i == 20) f_busy_mid = busy;
      end
      frame_start = 1'b0;
      light_raw   = 1'b0;
      f_pulses    = hits + misses - start;
   endtask

   task automatic shot(input string tag, input logic bb, input int bn,
                       input logic wb, input int wn, input logic exp_hit);
      trigger_raw = 1'b1;
      repeat (6) tick();
      chk({tag, "_armed"}, busy, 1);
      frame(bb, bn);
      chk({tag, "_black_busy"}, f_busy_mid, 1);
      frame(wb, wn);
      frame(1'b0, 0);
      chk({tag, "_hit"}, f_hit0, exp_hit);
      chk({tag, "_miss"}, f_miss0, !exp_hit);
      chk({tag, "_pulses"}, f_pulses, 1);
      trigger_raw = 1'b0;
      repeat (8) tick();
      chk({tag, "_idle"}, 32'(dut.state_q), 32'(IDLE));
   endtask

   initial begin
      reset       = 1'b1;
      frame_start = 1'b0;
      trigger_raw = 1'b0;
      light_raw   = 1'b0;
      repeat (3) tick();
      chk("rst_trigger", trigger, 0);
      chk("rst_busy",    busy,    0);
      chk("rst_hit",     hit,     0);
      chk("rst_miss",    miss,    0);
      chk("rst_state",   32'(dut.state_q), 32'(IDLE));
      reset = 1'b0;
      tick();

      // 1. bouncing trigger never settles, then a clean hold
      quiet = 1'b0;
      for (int i = 0; i < 20; i++) begin
         trigger_raw = ((i / 2) % 2 == 0);
         tick();
         quiet = quiet | trigger | busy | hit | miss;
      end
      chk("bounce_quiet", quiet, 0);
      trigger_raw = 1'b1;
      repeat (5) tick();
      chk("deb_early", trigger, 0);
      tick();
      chk("deb_rise", trigger, 1);
      chk("deb_busy", busy, 1);

      // 2. clean shot
      frame(1'b0, 0);
      chk("clean_black_busy", f_busy_mid, 1);
      frame(1'b1, 0);
      chk("clean_white_busy", f_busy_mid, 1);
      frame(1'b0, 0);
      chk("clean_hit",    f_hit0,   1);
      chk("clean_miss",   f_miss0,  0);
      chk("clean_busy",   f_busy0,  0);
      chk("clean_pulses", f_pulses, 1);
      trigger_raw = 1'b0;
      repeat (6) tick();
      chk("clean_release", trigger, 0);
      tick();
      chk("clean_idle", 32'(dut.state_q), 32'(IDLE));

      // 3. aim at a lamp
      shot("lamp", 1'b1, 0, 1'b1, 0, 1'b0);

      // 4. off target, then hold the trigger
      trigger_raw = 1'b1;
      repeat (6) tick();
      frame(1'b0, 0);
      frame(1'b0, 0);
      frame(1'b0, 0);
      chk("off_miss", f_miss0, 1);
      chk("off_hit",  f_hit0,  0);
      p0 = hits + misses;
      repeat (5) frame(1'b0, 0);
      chk("hold_no_refire", hits + misses - p0, 0);
      chk("hold_busy",  busy, 0);
      chk("hold_state", 32'(dut.state_q), 32'(WAIT_RELEASE));
      trigger_raw = 1'b0;
      repeat (8) tick();
      chk("off_idle", 32'(dut.state_q), 32'(IDLE));

      // thresholds: dark exactly DARK_MAX with lit exactly LIGHT_MIN scores
      shot("edge_hit",  1'b0, 1, 1'b0, 4, 1'b1);
      shot("lit_short", 1'b0, 0, 1'b0, 3, 1'b0);
      shot("dark_over", 1'b0, 2, 1'b1, 0, 1'b0);

      // 5. trigger rises on the frame_start edge
      p0 = hits + misses;
      trigger_raw = 1'b1;
      repeat (5) tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("coinc_trigger", trigger, 1);
      chk("coinc_armed",   32'(dut.state_q), 32'(ARMED));
      repeat (39) tick();
      chk("coinc_still_armed", 32'(dut.state_q), 32'(ARMED));
      trigger_raw = 1'b0;
      repeat (7) tick();
      chk("armed_release_idle", 32'(dut.state_q), 32'(IDLE));
      chk("armed_release_busy", busy, 0);

      trigger_raw = 1'b1;
      repeat (5) tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (39) tick();
      chk("coinc2_armed", 32'(dut.state_q), 32'(ARMED));
      frame(1'b0, 0);
      chk("coinc2_black", 32'(dut.state_q), 32'(BLACK_WIN));
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (10) tick();
      chk("coinc2_white", 32'(dut.state_q), 32'(WHITE_WIN));

      // 6. reset in WHITE_WIN with the trigger still held
      reset = 1'b1;
      tick();
      chk("abort_trigger", trigger, 0);
      chk("abort_busy",    busy,    0);
      chk("abort_hit",     hit,     0);
      chk("abort_miss",    miss,    0);
      chk("abort_state",   32'(dut.state_q), 32'(IDLE));
      reset = 1'b0;
      repeat (5) tick();
      chk("held_early", trigger, 0);
      tick();
      chk("held_fire", trigger, 1);
      chk("held_busy", busy, 1);
      chk("no_pulse_5_6", hits + misses - p0, 0);
      chk("never_both", both, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
